// File: rtl/ni_injector_if.sv
// Packet-in / flit-out / credit-return bundle between the core, the injector and
// the local router input port.
interface ni_injector_if #(
    parameter int NUM_ROUTERS      = 16,
    parameter int NUM_VC           = 4,
    parameter int FLITS_PER_PACKET = 4,
    parameter int DATA_WIDTH       = 32
);
    localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS);
    localparam int VC_BITS        = $clog2(NUM_VC);

    logic                                   pkt_valid;
    logic                                   pkt_ready;
    logic [ROUTER_ID_BITS-1:0]              pkt_dest;
    logic [FLITS_PER_PACKET*DATA_WIDTH-1:0] pkt_payload;
    logic                                   flit_valid;
    logic [1:0]                             flit_type;
    logic [VC_BITS-1:0]                     flit_vc;
    logic [ROUTER_ID_BITS-1:0]              flit_src;
    logic [ROUTER_ID_BITS-1:0]              flit_dest;
    logic [DATA_WIDTH-1:0]                  flit_data;
    logic                                   credit_valid;
    logic [VC_BITS-1:0]                     credit_vc;
    logic                                   credit_err;

    modport master (
        output pkt_valid, pkt_dest, pkt_payload, credit_valid, credit_vc,
        input  pkt_ready, flit_valid, flit_type, flit_vc, flit_src, flit_dest,
               flit_data, credit_err
    );

    modport slave (
        input  pkt_valid, pkt_dest, pkt_payload, credit_valid, credit_vc,
        output pkt_ready, flit_valid, flit_type, flit_vc, flit_src, flit_dest,
               flit_data, credit_err
    );
endinterface

// File: rtl/ni_injector.sv
// Network-interface injector: allocates a fully drained VC per packet and
// serialises the packet into HEAD/BODY/TAIL flits under credit flow control.
module ni_injector #(
    parameter int NUM_ROUTERS      = 16,
    parameter int ROUTER_ID_BITS   = $clog2(NUM_ROUTERS),
    parameter int NUM_VC           = 4,
    parameter int VC_BITS          = $clog2(NUM_VC),
    parameter int BUF_DEPTH        = 4,
    parameter int FLITS_PER_PACKET = 4,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ROUTER_ID_BITS-1:0] my_router_id,
    ni_injector_if.slave              bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = (FLITS_PER_PACKET > 2) ? $clog2(FLITS_PER_PACKET) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FLITS_PER_PACKET - 1);
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                                 state_r;
    logic [VC_BITS-1:0]                     vc_r;
    logic [IDX_W-1:0]                       idx_r;
    logic [ROUTER_ID_BITS-1:0]              dest_r;
    logic [FLITS_PER_PACKET*DATA_WIDTH-1:0] payload_r;
    logic [CNT_W-1:0]                       credit_cnt_r [NUM_VC];
    logic                                   flit_valid_r;
    logic [1:0]                             flit_type_r;
    logic [VC_BITS-1:0]                     flit_vc_r;
    logic [ROUTER_ID_BITS-1:0]              flit_src_r;
    logic [ROUTER_ID_BITS-1:0]              flit_dest_r;
    logic [DATA_WIDTH-1:0]                  flit_data_r;
    logic                                   credit_err_r;

    logic                  alloc_ok_s;
    logic [VC_BITS-1:0]    alloc_vc_s;
    logic                  send_s;
    logic [VC_BITS-1:0]    send_vc_s;
    logic [IDX_W-1:0]      send_idx_s;
    logic [1:0]            send_type_s;
    logic [DATA_WIDTH-1:0] send_data_s;
    logic [CNT_W-1:0]      next_cnt_s [NUM_VC];
    logic                  overflow_s;

    // Lowest-index VC whose router buffer is completely drained.
    always_comb begin
        alloc_ok_s = 1'b0;
        alloc_vc_s = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (!alloc_ok_s && (credit_cnt_r[v] == CNT_FULL)) begin
                alloc_ok_s = 1'b1;
                alloc_vc_s = VC_BITS'(v);
            end else begin
                alloc_vc_s = alloc_vc_s;
            end
        end
    end

    // Decide whether a flit leaves at this edge, on which VC and of which kind.
    always_comb begin
        send_s      = 1'b0;
        send_vc_s   = vc_r;
        send_idx_s  = idx_r;
        send_type_s = FLIT_BODY;
        case (state_r)
            ALLOC: begin
                if (alloc_ok_s) begin
                    send_s      = 1'b1;
                    send_vc_s   = alloc_vc_s;
                    send_idx_s  = '0;
                    send_type_s = FLIT_HEAD;
                end else begin
                    send_s = 1'b0;
                end
            end
            SEND: begin
                if (credit_cnt_r[vc_r] != '0) begin
                    send_s      = 1'b1;
                    send_type_s = (idx_r == IDX_LAST) ? FLIT_TAIL : FLIT_BODY;
                end else begin
                    send_s = 1'b0;
                end
            end
            default: begin
                send_s = 1'b0;
            end
        endcase
    end

    // Payload slice for the flit index being sent.
    always_comb begin
        send_data_s = '0;
        for (int k = 0; k < FLITS_PER_PACKET; k++) begin
            if (send_idx_s == IDX_W'(k)) begin
                send_data_s = payload_r[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                send_data_s = send_data_s;
            end
        end
    end

    // Credit bookkeeping; a credit beyond full saturates and is flagged.
    always_comb begin
        overflow_s = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            next_cnt_s[v] = credit_cnt_r[v];
            if (bus.credit_valid && (bus.credit_vc == VC_BITS'(v)) &&
                !(send_s && (send_vc_s == VC_BITS'(v)))) begin
                if (credit_cnt_r[v] == CNT_FULL) begin
                    overflow_s = 1'b1;
                end else begin
                    next_cnt_s[v] = credit_cnt_r[v] + CNT_W'(1);
                end
            end else if (send_s && (send_vc_s == VC_BITS'(v)) &&
                         !(bus.credit_valid && (bus.credit_vc == VC_BITS'(v)))) begin
                next_cnt_s[v] = credit_cnt_r[v] - CNT_W'(1);
            end else begin
                next_cnt_s[v] = credit_cnt_r[v];
            end
        end
    end

    // Packet FSM, credit counters and registered flit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            vc_r         <= '0;
            idx_r        <= '0;
            dest_r       <= '0;
            payload_r    <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_cnt_r[v] <= CNT_FULL;
            end
            flit_valid_r <= 1'b0;
            flit_type_r  <= 2'b00;
            flit_vc_r    <= '0;
            flit_src_r   <= '0;
            flit_dest_r  <= '0;
            flit_data_r  <= '0;
            credit_err_r <= 1'b0;
        end else begin
            credit_cnt_r <= next_cnt_s;
            credit_err_r <= overflow_s;
            flit_valid_r <= send_s;
            if (send_s) begin
                flit_type_r <= send_type_s;
                flit_vc_r   <= send_vc_s;
                flit_src_r  <= my_router_id;
                flit_dest_r <= dest_r;
                flit_data_r <= send_data_s;
            end else begin
                flit_type_r <= flit_type_r;
            end
            case (state_r)
                IDLE: begin
                    if (bus.pkt_valid) begin
                        dest_r    <= bus.pkt_dest;
                        payload_r <= bus.pkt_payload;
                        idx_r     <= '0;
                        state_r   <= ALLOC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ALLOC: begin
                    if (alloc_ok_s) begin
                        vc_r    <= alloc_vc_s;
                        idx_r   <= IDX_W'(1);
                        state_r <= SEND;
                    end else begin
                        state_r <= ALLOC;
                    end
                end
                SEND: begin
                    if (send_s) begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= (idx_r == IDX_LAST) ? IDLE : SEND;
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.pkt_ready  = (state_r == IDLE);
    assign bus.flit_valid = flit_valid_r;
    assign bus.flit_type  = flit_type_r;
    assign bus.flit_vc    = flit_vc_r;
    assign bus.flit_src   = flit_src_r;
    assign bus.flit_dest  = flit_dest_r;
    assign bus.flit_data  = flit_data_r;
    assign bus.credit_err = credit_err_r;

endmodule

// File: tb/tb_ni_injector.sv
// Bench for ni_injector: packet/credit-level reference model compared every
// cycle, plus directed literal checks, including a BUF_DEPTH=2 instance.
module tb_ni_injector;
    localparam int NV  = 4;
    localparam int FPP = 4;
    localparam int DW  = 32;
    localparam int BD  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] my_id;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    ni_injector_if #(.NUM_ROUTERS(16), .NUM_VC(NV), .FLITS_PER_PACKET(FPP), .DATA_WIDTH(DW)) bus1();
    ni_injector_if #(.NUM_ROUTERS(16), .NUM_VC(NV), .FLITS_PER_PACKET(FPP), .DATA_WIDTH(DW)) bus2();

    ni_injector #(.NUM_ROUTERS(16), .NUM_VC(NV), .BUF_DEPTH(BD), .FLITS_PER_PACKET(FPP), .DATA_WIDTH(DW))
        u_dut (.clk(clk), .rst_n(rst_n), .my_router_id(my_id), .bus(bus1));

    ni_injector #(.NUM_ROUTERS(16), .NUM_VC(NV), .BUF_DEPTH(2), .FLITS_PER_PACKET(FPP), .DATA_WIDTH(DW))
        u_dut2 (.clk(clk), .rst_n(rst_n), .my_router_id(4'd9), .bus(bus2));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: packet queue of depth one, per-VC credit totals.
    bit          m_busy, m_alloc;
    int          m_vc, m_k;
    logic [3:0]  m_dest;
    logic [127:0] m_pay;
    int          m_cr [NV];
    logic        e_valid, e_err;
    logic [1:0]  e_type, e_vc;
    logic [3:0]  e_src, e_dest;
    logic [31:0] e_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_alloc = 1'b0; m_vc = 0; m_k = 0;
            m_dest = '0; m_pay = '0;
            for (int i = 0; i < NV; i++) m_cr[i] = BD;
            e_valid = 1'b0; e_err = 1'b0; e_type = '0; e_vc = '0;
            e_src = '0; e_dest = '0; e_data = '0;
        end else begin : step
            int  pre [NV];
            bit  sent;
            int  svc;
            int  d;
            pre  = m_cr;
            sent = 1'b0;
            svc  = 0;
            if (!m_busy) begin
                if (bus1.pkt_valid) begin
                    m_busy = 1'b1; m_alloc = 1'b0; m_k = 0;
                    m_dest = bus1.pkt_dest; m_pay = bus1.pkt_payload;
                end
            end else if (!m_alloc) begin
                for (int v = 0; v < NV; v++) begin
                    if (pre[v] == BD) begin
                        svc = v; sent = 1'b1;
                        break;
                    end
                end
                if (sent) begin
                    m_alloc = 1'b1; m_vc = svc;
                end
            end else if (pre[m_vc] > 0) begin
                sent = 1'b1; svc = m_vc;
            end
            if (sent) begin
                e_type = (m_k == 0) ? 2'd1 : ((m_k == FPP - 1) ? 2'd3 : 2'd2);
                e_vc   = 2'(svc);
                e_src  = my_id;
                e_dest = m_dest;
                e_data = m_pay[m_k*DW +: DW];
                if (m_k == FPP - 1) m_busy = 1'b0;
                m_k++;
            end
            e_valid = sent;
            e_err   = 1'b0;
            for (int v = 0; v < NV; v++) begin
                d = ((bus1.credit_valid && bus1.credit_vc == 2'(v)) ? 1 : 0)
                  - ((sent && svc == v) ? 1 : 0);
                if (d > 0 && pre[v] == BD) e_err = 1'b1;
                else m_cr[v] = pre[v] + d;
            end
        end
    end

    // Every-cycle comparison of the full-depth instance against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("m_pkt_ready",  64'(bus1.pkt_ready),  64'(!m_busy));
            check("m_flit_valid", 64'(bus1.flit_valid), 64'(e_valid));
            check("m_flit_type",  64'(bus1.flit_type),  64'(e_type));
            check("m_flit_vc",    64'(bus1.flit_vc),    64'(e_vc));
            check("m_flit_src",   64'(bus1.flit_src),   64'(e_src));
            check("m_flit_dest",  64'(bus1.flit_dest),  64'(e_dest));
            check("m_flit_data",  64'(bus1.flit_data),  64'(e_data));
            check("m_credit_err", 64'(bus1.credit_err), 64'(e_err));
        end
    end

    // Offer one packet when ready; returns at the negedge of the ALLOC cycle.
    task automatic accept(input bit two, input logic [3:0] d, input logic [127:0] p);
        int t = 0;
        while (!(two ? bus2.pkt_ready : bus1.pkt_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", 64'd0, 64'd1);
        if (two) begin
            bus2.pkt_valid = 1'b1; bus2.pkt_dest = d; bus2.pkt_payload = p;
        end else begin
            bus1.pkt_valid = 1'b1; bus1.pkt_dest = d; bus1.pkt_payload = p;
        end
        @(negedge clk);
        bus1.pkt_valid = 1'b0;
        bus2.pkt_valid = 1'b0;
    endtask

    task automatic credits1(input logic [1:0] vc, input int n);
        for (int i = 0; i < n; i++) begin
            bus1.credit_valid = 1'b1; bus1.credit_vc = vc;
            @(negedge clk);
        end
        bus1.credit_valid = 1'b0;
    endtask

    task automatic flit1(input string nm, input logic [1:0] ty, input logic [1:0] vc, input logic [31:0] dat);
        check({nm, "_valid"}, 64'(bus1.flit_valid), 64'd1);
        check({nm, "_type"},  64'(bus1.flit_type),  64'(ty));
        check({nm, "_vc"},    64'(bus1.flit_vc),    64'(vc));
        check({nm, "_data"},  64'(bus1.flit_data),  64'(dat));
    endtask

    initial begin
        rst_n = 1'b0; my_id = 4'd0;
        bus1.pkt_valid = 1'b0; bus1.pkt_dest = '0; bus1.pkt_payload = '0;
        bus1.credit_valid = 1'b0; bus1.credit_vc = '0;
        bus2.pkt_valid = 1'b0; bus2.pkt_dest = '0; bus2.pkt_payload = '0;
        bus2.credit_valid = 1'b0; bus2.credit_vc = '0;
        repeat (3) @(negedge clk);
        check("rst_pkt_ready",  64'(bus1.pkt_ready),  64'd1);
        check("rst_flit_valid", 64'(bus1.flit_valid), 64'd0);
        check("rst_flit_type",  64'(bus1.flit_type),  64'd0);
        check("rst_flit_data",  64'(bus1.flit_data),  64'd0);
        check("rst_credit_err", 64'(bus1.credit_err), 64'd0);
        check("rst2_pkt_ready", 64'(bus2.pkt_ready),  64'd1);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single packet on a fresh injector
        accept(1'b0, 4'd5, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        check("p1_alloc_gap", 64'(bus1.flit_valid), 64'd0);
        @(negedge clk); flit1("p1_head", 2'b01, 2'd0, 32'hA0);
        check("p1_dest", 64'(bus1.flit_dest), 64'd5);
        check("p1_src",  64'(bus1.flit_src),  64'd0);
        @(negedge clk); flit1("p1_body1", 2'b10, 2'd0, 32'hA1);
        @(negedge clk); flit1("p1_body2", 2'b10, 2'd0, 32'hA2);
        @(negedge clk); flit1("p1_tail", 2'b11, 2'd0, 32'hA3);
        check("p1_ready_at_tail", 64'(bus1.pkt_ready), 64'd1);

        // Packets 2-4 take VC1..VC3; dest equal to own ID goes out normally
        my_id = 4'd6;
        accept(1'b0, 4'd6, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        @(negedge clk); flit1("p2_head", 2'b01, 2'd1, 32'hB0);
        check("p2_dest", 64'(bus1.flit_dest), 64'd6);
        check("p2_src",  64'(bus1.flit_src),  64'd6);
        accept(1'b0, 4'd12, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        @(negedge clk); flit1("p3_head", 2'b01, 2'd2, 32'hC0);
        accept(1'b0, 4'd15, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        @(negedge clk); flit1("p4_head", 2'b01, 2'd3, 32'hD0);
        accept(1'b0, 4'd3, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        repeat (5) @(negedge clk);
        check("p5_stall_valid", 64'(bus1.flit_valid), 64'd0);
        check("p5_stall_ready", 64'(bus1.pkt_ready),  64'd0);

        // VC0 refilled, then credits keep flowing while packet 5 is sent on VC0
        for (int i = 0; i < 8; i++) begin
            bus1.credit_valid = 1'b1; bus1.credit_vc = 2'd0;
            @(negedge clk);
            if (i == 3) check("p5_no_early_head", 64'(bus1.flit_valid), 64'd0);
            if (i == 4) flit1("p5_head", 2'b01, 2'd0, 32'hE0);
            if (i == 7) begin
                flit1("p5_tail", 2'b11, 2'd0, 32'hE3);
                check("p5_no_err", 64'(bus1.credit_err), 64'd0);
            end
        end
        bus1.credit_valid = 1'b0;
        accept(1'b0, 4'd7, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
        @(negedge clk); flit1("p6_head_vc0_full", 2'b01, 2'd0, 32'hF0);
        repeat (3) @(negedge clk);

        // Overflow on VC2: fifth credit saturates and pulses credit_err
        for (int i = 0; i < 5; i++) begin
            bus1.credit_valid = 1'b1; bus1.credit_vc = 2'd2;
            @(negedge clk);
            if (i == 3) check("ovf_not_yet", 64'(bus1.credit_err), 64'd0);
            if (i == 4) check("ovf_pulse",   64'(bus1.credit_err), 64'd1);
        end
        bus1.credit_valid = 1'b0;
        @(negedge clk);
        check("ovf_one_cycle", 64'(bus1.credit_err), 64'd0);
        accept(1'b0, 4'd9, {32'h73, 32'h72, 32'h71, 32'h70});
        @(negedge clk); flit1("p7_head_vc2", 2'b01, 2'd2, 32'h70);
        repeat (3) @(negedge clk);

        // Reset in the middle of a packet
        credits1(2'd3, 4);
        accept(1'b0, 4'd1, {32'h83, 32'h82, 32'h81, 32'h80});
        @(negedge clk); flit1("p8_head", 2'b01, 2'd3, 32'h80);
        @(negedge clk); flit1("p8_body", 2'b10, 2'd3, 32'h81);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus1.flit_valid), 64'd0);
        check("mid_rst_ready", 64'(bus1.pkt_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        accept(1'b0, 4'd2, {32'h93, 32'h92, 32'h91, 32'h90});
        @(negedge clk); flit1("p9_head_after_rst", 2'b01, 2'd0, 32'h90);
        repeat (3) @(negedge clk);

        // Two-deep router buffer: stall after two flits, one credit per 3 cycles
        accept(1'b1, 4'd7, {32'h5B3, 32'h5B2, 32'h5B1, 32'h5B0});
        @(negedge clk);
        check("bd2_head_type", 64'(bus2.flit_type), 64'd1);
        check("bd2_head_data", 64'(bus2.flit_data), 64'h5B0);
        check("bd2_head_src",  64'(bus2.flit_src),  64'd9);
        check("bd2_head_dest", 64'(bus2.flit_dest), 64'd7);
        @(negedge clk);
        check("bd2_body_type", 64'(bus2.flit_type), 64'd2);
        check("bd2_body_data", 64'(bus2.flit_data), 64'h5B1);
        @(negedge clk); check("bd2_stall_a", 64'(bus2.flit_valid), 64'd0);
        @(negedge clk); check("bd2_stall_b", 64'(bus2.flit_valid), 64'd0);
        for (int j = 0; j < 2; j++) begin
            bus2.credit_valid = 1'b1; bus2.credit_vc = 2'd0;
            @(negedge clk);
            bus2.credit_valid = 1'b0;
            check("bd2_wait", 64'(bus2.flit_valid), 64'd0);
            @(negedge clk);
            check("bd2_flit_valid", 64'(bus2.flit_valid), 64'd1);
            check("bd2_flit_type",  64'(bus2.flit_type),  (j == 0) ? 64'd2 : 64'd3);
            check("bd2_flit_data",  64'(bus2.flit_data),  (j == 0) ? 64'h5B2 : 64'h5B3);
            check("bd2_flit_vc",    64'(bus2.flit_vc),    64'd0);
            @(negedge clk);
            check("bd2_gap", 64'(bus2.flit_valid), 64'd0);
        end
        check("bd2_ready_after", 64'(bus2.pkt_ready), 64'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
